// File: rtl/sync_s2f_update_arbiter.sv
// Purpose: holds one pending update per synchronised channel and drains them round-robin onto one write port.
// Latency: an accepted strobe is pending one edge later and presented on the output one edge after that (minimum).
// Backpressure: output words stay stable while out_valid & !out_ready; later strobes overwrite pending words and flag overflow.
module sync_s2f_update_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CH_W       = 2
) (
    input  logic                         fast_clk,
    input  logic                         fast_rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_data_set,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH-1:0]            pending,
    output logic [NUM_CH-1:0]            overflow,
    input  logic [NUM_CH-1:0]            overflow_clr
);

    // Latest captured word per channel.
    logic [DATA_WIDTH-1:0] hold_q [NUM_CH];
    // Last granted channel; search starts one above it.
    logic [CH_W-1:0]       rr_q;

    logic [NUM_CH-1:0]     capture;
    logic [NUM_CH-1:0]     grant_oh;
    logic [NUM_CH-1:0]     take;
    logic                  grant_vld;
    logic [CH_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  load_ok;
    logic                  do_grant;
    logic [NUM_CH-1:0]     pending_d;
    logic [NUM_CH-1:0]     overflow_d;

    // Round-robin search over registered pending bits, rr+1 first with wrap-around.
    // Offsets are walked from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        grant_oh   = '0;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((i == ((int'(rr_q) + k) % NUM_CH)) && pending[i]) begin
                    grant_oh    = '0;
                    grant_oh[i] = 1'b1;
                    grant_vld   = 1'b1;
                    grant_idx   = CH_W'(i);
                    grant_data  = hold_q[i];
                end
            end
        end
    end

    // Output-stage load condition plus pending/overflow next state.
    // A capture on the channel being granted refills it, so pending stays set with no overflow.
    always_comb begin
        load_ok    = !out_valid || out_ready;
        do_grant   = load_ok && grant_vld;
        capture    = ch_data_set & ch_enable;
        take       = do_grant ? grant_oh : '0;
        pending_d  = capture | (pending & ~take);
        overflow_d = (overflow & ~overflow_clr) | (capture & pending & ~take);
    end

    // Per-channel hold registers: latest accepted strobe wins.
    always_ff @(posedge fast_clk) begin
        if (fast_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture[i]) begin
                    hold_q[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Pending and sticky overflow flags.
    always_ff @(posedge fast_clk) begin
        if (fast_rst) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= pending_d;
            overflow <= overflow_d;
        end
    end

    // Output register and round-robin pointer; ch0 is searched first after reset.
    always_ff @(posedge fast_clk) begin
        if (fast_rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            rr_q      <= CH_W'(NUM_CH - 1);
        end else if (do_grant) begin
            out_data  <= grant_data;
            out_ch    <= grant_idx;
            out_valid <= 1'b1;
            rr_q      <= grant_idx;
        end else if (load_ok) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_s2f_update_arbiter.sv
// Purpose: directed checks of capture, round-robin order, stall, overflow and reset of the update arbiter.
// Latency: samples outputs 1 ns after each rising edge, drives inputs at the same point.
// Backpressure: out_ready is driven explicitly per step.
module tb_sync_s2f_update_arbiter;

    localparam int NUM_CH     = 4;
    localparam int DATA_WIDTH = 32;
    localparam int CH_W       = 2;

    logic                         fast_clk = 1'b0;
    logic                         fast_rst;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_data_set;
    logic [NUM_CH-1:0]            ch_enable;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_CH-1:0]            pending;
    logic [NUM_CH-1:0]            overflow;
    logic [NUM_CH-1:0]            overflow_clr;

    int passed = 0;
    int total  = 0;

    sync_s2f_update_arbiter #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .CH_W       (CH_W)
    ) dut (
        .fast_clk     (fast_clk),
        .fast_rst     (fast_rst),
        .ch_data      (ch_data),
        .ch_data_set  (ch_data_set),
        .ch_enable    (ch_enable),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pending      (pending),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    // Free-running 100 MHz clock.
    always #5 fast_clk = ~fast_clk;

    task automatic step();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [DATA_WIDTH-1:0] v);
        ch_data[ch*DATA_WIDTH +: DATA_WIDTH] = v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [CH_W-1:0] ch,
                             input logic [DATA_WIDTH-1:0] d);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        if (v) begin
            check({tag, ".ch"},   64'(out_ch),   64'(ch));
            check({tag, ".data"}, 64'(out_data), 64'(d));
        end
    endtask

    task automatic do_reset();
        fast_rst = 1'b1;
        step();
        fast_rst = 1'b0;
    endtask

    initial begin
        fast_rst     = 1'b1;
        ch_data      = '0;
        ch_data_set  = '0;
        ch_enable    = '1;
        out_ready    = 1'b1;
        overflow_clr = '0;
        step();
        step();

        // 1: reset state and single-update latency
        check("rst.valid",    64'(out_valid), 64'd0);
        check("rst.ch",       64'(out_ch),    64'd0);
        check("rst.data",     64'(out_data),  64'd0);
        check("rst.pending",  64'(pending),   64'd0);
        check("rst.overflow", 64'(overflow),  64'd0);
        fast_rst = 1'b0;
        set_ch(2, 32'hA5A5_0002);
        ch_data_set = 4'b0100;
        step();
        ch_data_set = '0;
        check("t1.pend", 64'(pending), 64'h4);
        check_out("t1.not_yet", 1'b0, 2'd0, 32'h0);
        step();
        check_out("t1.out", 1'b1, 2'd2, 32'hA5A5_0002);
        check("t1.pend_clr", 64'(pending), 64'h0);
        step();
        check_out("t1.one_cycle", 1'b0, 2'd0, 32'h0);

        // 2: all four channels at once, then wrap from rr=3
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 32'h10 + 32'(i));
        ch_data_set = 4'b1111;
        step();
        ch_data_set = '0;
        check("t2.pend_all", 64'(pending), 64'hF);
        step();
        check_out("t2.g0", 1'b1, 2'd0, 32'h10);
        step();
        check_out("t2.g1", 1'b1, 2'd1, 32'h11);
        step();
        check_out("t2.g2", 1'b1, 2'd2, 32'h12);
        step();
        check_out("t2.g3", 1'b1, 2'd3, 32'h13);
        set_ch(0, 32'h20);
        set_ch(1, 32'h21);
        ch_data_set = 4'b0011;
        step();
        ch_data_set = '0;
        check_out("t2.gap", 1'b0, 2'd0, 32'h0);
        step();
        check_out("t2.w0", 1'b1, 2'd0, 32'h20);
        step();
        check_out("t2.w1", 1'b1, 2'd1, 32'h21);
        step();
        check_out("t2.idle", 1'b0, 2'd0, 32'h0);

        // 3+4: stall on ch0, ch1 overwritten while pending, then drain with no gap
        out_ready = 1'b0;
        set_ch(0, 32'h01);
        ch_data_set = 4'b0001;
        step();
        ch_data_set = '0;
        step();
        check_out("t4.load", 1'b1, 2'd0, 32'h01);
        set_ch(1, 32'h11);
        ch_data_set = 4'b0010;
        step();
        ch_data_set = '0;
        check_out("t4.stall1", 1'b1, 2'd0, 32'h01);
        check("t3.pend1", 64'(pending), 64'h2);
        step();
        check_out("t4.stall2", 1'b1, 2'd0, 32'h01);
        step();
        check_out("t4.stall3", 1'b1, 2'd0, 32'h01);
        check("t3.no_ovf_yet", 64'(overflow), 64'h0);
        set_ch(1, 32'h22);
        ch_data_set = 4'b0010;
        step();
        ch_data_set = '0;
        check_out("t4.stall4", 1'b1, 2'd0, 32'h01);
        check("t3.ovf_set", 64'(overflow), 64'h2);
        step();
        check_out("t4.stall5", 1'b1, 2'd0, 32'h01);
        out_ready = 1'b1;
        step();
        check_out("t3.latest", 1'b1, 2'd1, 32'h22);
        check("t3.pend_drained", 64'(pending), 64'h0);
        step();
        check_out("t3.single", 1'b0, 2'd0, 32'h0);
        check("t3.ovf_sticky", 64'(overflow), 64'h2);
        overflow_clr = 4'b0010;
        step();
        overflow_clr = '0;
        check("t3.ovf_clr", 64'(overflow), 64'h0);

        // 5: capture on ch3 in the cycle ch3 is granted
        set_ch(3, 32'h33);
        ch_data_set = 4'b1000;
        step();
        set_ch(3, 32'h77);
        ch_data_set = 4'b1000;
        step();
        ch_data_set = '0;
        check_out("t5.old", 1'b1, 2'd3, 32'h33);
        check("t5.pend_kept", 64'(pending), 64'h8);
        check("t5.no_ovf", 64'(overflow), 64'h0);
        step();
        check_out("t5.new", 1'b1, 2'd3, 32'h77);
        step();
        check_out("t5.idle", 1'b0, 2'd0, 32'h0);

        // 6: disabled channel ignored; reset discards pending and restores ch0 priority
        ch_enable = 4'b1011;
        set_ch(2, 32'hDEAD);
        ch_data_set = 4'b0100;
        step();
        ch_data_set = '0;
        ch_enable = '1;
        check("t6.disabled", 64'(pending), 64'h0);
        step();
        check_out("t6.no_out", 1'b0, 2'd0, 32'h0);
        set_ch(1, 32'h61);
        set_ch(2, 32'h62);
        set_ch(3, 32'h63);
        ch_data_set = 4'b1110;
        step();
        ch_data_set = '0;
        step();
        check_out("t6.g1", 1'b1, 2'd1, 32'h61);
        out_ready = 1'b0;
        set_ch(0, 32'h60);
        ch_data_set = 4'b0001;
        step();
        ch_data_set = '0;
        check("t6.three_pend", 64'(pending), 64'hD);
        fast_rst = 1'b1;
        step();
        fast_rst = 1'b0;
        out_ready = 1'b1;
        check_out("t6.rst_valid", 1'b0, 2'd0, 32'h0);
        check("t6.rst_pend", 64'(pending), 64'h0);
        set_ch(0, 32'h70);
        set_ch(2, 32'h72);
        ch_data_set = 4'b0101;
        step();
        ch_data_set = '0;
        step();
        check_out("t6.first_ch0", 1'b1, 2'd0, 32'h70);
        step();
        check_out("t6.then_ch2", 1'b1, 2'd2, 32'h72);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
